// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS-subset control unit.
// master = controller side, slave = datapath side.
interface mc_ctrl_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         op;
  logic [5:0]         func;
  logic               zero;
  logic               mem_ready;
  logic               pc_wr;
  logic               ir_wr;
  logic               memrd;
  logic               memwr;
  logic               regwr;
  logic               regdst;
  logic               alusrc;
  logic               memtoreg;
  logic               extop;
  logic [1:0]         pcsrc;
  logic [ALUOP_W-1:0] aluop;
  logic [2:0]         state;
  logic               retire;
  logic               illegal;

  modport master (
    input  op, func, zero, mem_ready,
    output pc_wr, ir_wr, memrd, memwr, regwr,
    output regdst, alusrc, memtoreg, extop,
    output pcsrc, aluop, state, retire, illegal
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_wr, ir_wr, memrd, memwr, regwr,
    input  regdst, alusrc, memtoreg, extop,
    input  pcsrc, aluop, state, retire, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for a small MIPS subset,
// with a sticky illegal-instruction flag and a per-instruction retire pulse.
module mc_ctrl #(
  parameter int ALUOP_W     = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  mc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;

  logic       is_r, is_ori, is_addiu, is_lw, is_sw, is_beq, is_j, legal;
  logic       r_ok;
  logic [2:0] r_alu;
  logic       rdy;

  logic       pc_wr_c, ir_wr_c, memrd_c, memwr_c, regwr_c, retire_c;
  logic [1:0] pcsrc_c;
  logic [2:0] aluop_c;

  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (bus.func)
      6'b100001: r_alu = ALU_ADD;
      6'b100011: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      6'b101010: r_alu = ALU_SLT;
      default:   r_ok  = 1'b0;
    endcase
  end

  assign is_r     = (bus.op == OP_RTYPE) && r_ok;
  assign is_ori   = (bus.op == OP_ORI);
  assign is_addiu = (bus.op == OP_ADDIU);
  assign is_lw    = (bus.op == OP_LW);
  assign is_sw    = (bus.op == OP_SW);
  assign is_beq   = (bus.op == OP_BEQ);
  assign is_j     = (bus.op == OP_J);
  assign legal    = is_r | is_ori | is_addiu | is_lw | is_sw | is_beq | is_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    pc_wr_c   = 1'b0;
    ir_wr_c   = 1'b0;
    memrd_c   = 1'b0;
    memwr_c   = 1'b0;
    regwr_c   = 1'b0;
    retire_c  = 1'b0;
    pcsrc_c   = 2'b00;
    aluop_c   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        if (rdy) begin
          ir_wr_c = 1'b1;
          pc_wr_c = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else       illegal_d = 1'b1;
      end
      S_EXEC: begin
        if (is_r) begin
          aluop_c = r_alu;
          state_d = S_WB;
        end else if (is_ori) begin
          aluop_c = ALU_OR;
          state_d = S_WB;
        end else if (is_addiu) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq) begin
          aluop_c  = ALU_SUB;
          pcsrc_c  = 2'b01;
          pc_wr_c  = bus.zero;
          retire_c = 1'b1;
        end else if (is_j) begin
          pcsrc_c  = 2'b10;
          pc_wr_c  = 1'b1;
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        // Strobe stays up for every wait cycle until memory accepts it.
        if (is_lw) begin
          memrd_c = 1'b1;
          state_d = rdy ? S_WB : S_MEM;
        end else if (is_sw) begin
          memwr_c  = 1'b1;
          retire_c = rdy;
          state_d  = rdy ? S_FETCH : S_MEM;
        end
      end
      S_WB: begin
        regwr_c  = 1'b1;
        retire_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks strobes combinationally so they drop without a clock edge.
  assign bus.pc_wr    = pc_wr_c  & ~rst;
  assign bus.ir_wr    = ir_wr_c  & ~rst;
  assign bus.memrd    = memrd_c  & ~rst;
  assign bus.memwr    = memwr_c  & ~rst;
  assign bus.regwr    = regwr_c  & ~rst;
  assign bus.retire   = retire_c & ~rst;
  assign bus.pcsrc    = pcsrc_c;
  assign bus.aluop    = ALUOP_W'(aluop_c);
  assign bus.regdst   = is_r;
  assign bus.alusrc   = is_ori | is_addiu | is_lw | is_sw;
  assign bus.memtoreg = is_lw;
  assign bus.extop    = is_addiu | is_lw | is_sw;
  assign bus.state    = state_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: reset checks, a directed instruction table, async-reset
// corner cases, random instruction streams against an instruction-level model.
module tb_mc_ctrl;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.ALUOP_W(3)) bus ();
  mc_ctrl_if #(.ALUOP_W(3)) bus2 ();

  mc_ctrl #(.ALUOP_W(3), .MEM_WAIT_EN(1'b1)) dut  (.clk(clk), .rst(rst),  .bus(bus.master));
  mc_ctrl #(.ALUOP_W(3), .MEM_WAIT_EN(1'b0)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.master));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int lat, ret, ret_last, regwr, memwr, mrd, pcwr, irwr, aluop, sel, ill, viol, done;
  } res_t;

  typedef struct {
    logic [5:0] op, func;
    logic       zero;
    int         fst, mst;
    res_t       e;
  } vec_t;

  typedef enum int {K_R, K_I, K_L, K_S, K_B, K_J, K_X} kind_t;

  typedef struct {
    logic [5:0] op, func;
    int         aluop;
    kind_t      kind;
    int         sel;   // {regdst, alusrc, memtoreg, extop}
  } isa_t;

  isa_t isa [11];
  vec_t vt  [16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk(int lat, int ret, int regwr, int memwr, int mrd,
                              int pcwr, int aluop, int sel, int ill);
    res_t r;
    r.lat = lat; r.ret = ret; r.ret_last = ret; r.regwr = regwr; r.memwr = memwr;
    r.mrd = mrd; r.pcwr = pcwr; r.irwr = 1; r.aluop = aluop; r.sel = sel;
    r.ill = ill; r.viol = 0; r.done = 1;
    return r;
  endfunction

  function automatic logic [47:0] mkrdy(int fst, int mst);
    logic [47:0] r = '1;
    for (int i = 0; i < fst; i++) r[i] = 1'b0;
    for (int i = 0; i < mst; i++) r[fst + 3 + i] = 1'b0;
    return r;
  endfunction

  function automatic bit is_legal(logic [5:0] op, logic [5:0] func);
    for (int i = 0; i < 11; i++)
      if (isa[i].op == op && (isa[i].kind != K_R || isa[i].func == func)) return 1'b1;
    return 1'b0;
  endfunction

  // Instruction-level reference: walk the phase list the instruction class
  // implies, spending extra cycles wherever memory is not ready.
  function automatic res_t model(kind_t k, int alu, int sel, logic zero,
                                 logic [47:0] rdy, int ill_prev);
    res_t r = mk(0, 0, 0, 0, 0, 1, -1, -1, 1);
    int t = 0;
    while (!rdy[t]) t++;
    t++;
    t++;
    if (k == K_X) begin
      r.lat = t;
      return r;
    end
    t++;
    r.ill = ill_prev;
    r.ret = 1; r.ret_last = 1;
    r.aluop = (k == K_J) ? -1 : alu;
    r.sel = sel;
    r.pcwr = 1 + ((k == K_J) ? 1 : 0) + ((k == K_B && zero) ? 1 : 0);
    if (k == K_L || k == K_S) begin
      int w = 0;
      while (!rdy[t]) begin t++; w++; end
      t++;
      if (k == K_S) r.memwr = w + 1;
      else          r.mrd   = w + 1;
    end
    if (k == K_R || k == K_I || k == K_L) begin
      t++;
      r.regwr = 1;
    end
    r.lat = t;
    return r;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input logic zero,
                           input logic [47:0] rdy, output res_t m);
    bit left = 1'b0;
    bit done = 1'b0;
    logic [2:0] st;
    m = mk(0, 0, 0, 0, 0, 0, -1, -1, 0);
    m.irwr = 0; m.done = 0;
    bus.op = op; bus.func = func; bus.zero = zero;
    for (int k = 0; k < 48 && !done; k++) begin
      bus.mem_ready = rdy[k];
      #1;
      st = bus.state;
      if (st == 3'd0 && left) begin
        done  = 1'b1;
        m.lat = k;
      end else begin
        if (st != 3'd0) left = 1'b1;
        m.ret      += int'(bus.retire);
        m.ret_last  = int'(bus.retire);
        m.regwr    += int'(bus.regwr);
        m.memwr    += int'(bus.memwr);
        m.pcwr     += int'(bus.pc_wr);
        m.irwr     += int'(bus.ir_wr);
        if (st == 3'd3) m.mrd += int'(bus.memrd);
        if (st == 3'd2) begin
          m.aluop = int'(bus.aluop);
          m.sel   = int'({bus.regdst, bus.alusrc, bus.memtoreg, bus.extop});
        end
        if (st == 3'd1 && (bus.pc_wr | bus.ir_wr | bus.memrd | bus.memwr | bus.regwr | bus.retire))
          m.viol++;
        if (st != 3'd2 && bus.aluop != 3'd0) m.viol++;
        if (st != 3'd3 && bus.memwr) m.viol++;
        if (st != 3'd4 && bus.regwr) m.viol++;
        @(posedge clk); #1;
      end
    end
    m.ill  = int'(bus.illegal);
    m.done = int'(done);
  endtask

  task automatic compare(input string tag, input res_t m, input res_t e);
    chk({tag, ".done"},  m.done,  e.done);
    chk({tag, ".lat"},   m.lat,   e.lat);
    chk({tag, ".retire"}, m.ret,  e.ret);
    chk({tag, ".ret_last"}, m.ret_last, e.ret_last);
    chk({tag, ".regwr"}, m.regwr, e.regwr);
    chk({tag, ".memwr"}, m.memwr, e.memwr);
    chk({tag, ".memrd_mem"}, m.mrd, e.mrd);
    chk({tag, ".pc_wr"}, m.pcwr,  e.pcwr);
    chk({tag, ".ir_wr"}, m.irwr,  e.irwr);
    chk({tag, ".illegal"}, m.ill, e.ill);
    chk({tag, ".viol"},  m.viol,  e.viol);
    if (e.aluop >= 0) chk({tag, ".aluop"}, m.aluop, e.aluop);
    if (e.sel >= 0)   chk({tag, ".sel"},   m.sel,   e.sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m, e;
    int   ill_sticky;
    int   lat2, memwr2;
    logic [47:0] rdy;
    logic [5:0]  rop, rfunc;
    logic        rz;
    int          idx;

    isa[0]  = '{6'h00, 6'h21, 0, K_R, 8};
    isa[1]  = '{6'h00, 6'h23, 1, K_R, 8};
    isa[2]  = '{6'h00, 6'h24, 3, K_R, 8};
    isa[3]  = '{6'h00, 6'h25, 2, K_R, 8};
    isa[4]  = '{6'h00, 6'h2A, 4, K_R, 8};
    isa[5]  = '{6'h0D, 6'h00, 2, K_I, 4};
    isa[6]  = '{6'h09, 6'h00, 0, K_I, 5};
    isa[7]  = '{6'h23, 6'h00, 0, K_L, 7};
    isa[8]  = '{6'h2B, 6'h00, 0, K_S, 5};
    isa[9]  = '{6'h04, 6'h00, 1, K_B, 0};
    isa[10] = '{6'h02, 6'h00, 0, K_J, 0};

    //            op     func   z     fst mst  lat ret rw mw mrd pcw alu sel ill
    vt[0]  = '{6'h00, 6'h21, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  0,  8, 0)};
    vt[1]  = '{6'h00, 6'h23, 1'b1, 1, 0, mk(5, 1, 1, 0, 0, 1,  1,  8, 0)};
    vt[2]  = '{6'h00, 6'h24, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  3,  8, 0)};
    vt[3]  = '{6'h00, 6'h25, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  2,  8, 0)};
    vt[4]  = '{6'h00, 6'h2A, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  4,  8, 0)};
    vt[5]  = '{6'h0D, 6'h3F, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  2,  4, 0)};
    vt[6]  = '{6'h09, 6'h00, 1'b0, 2, 0, mk(6, 1, 1, 0, 0, 1,  0,  5, 0)};
    vt[7]  = '{6'h23, 6'h00, 1'b0, 0, 2, mk(7, 1, 1, 0, 3, 1,  0,  7, 0)};
    vt[8]  = '{6'h2B, 6'h00, 1'b0, 0, 0, mk(4, 1, 0, 1, 0, 1,  0,  5, 0)};
    vt[9]  = '{6'h2B, 6'h00, 1'b0, 1, 1, mk(6, 1, 0, 2, 0, 1,  0,  5, 0)};
    vt[10] = '{6'h04, 6'h00, 1'b1, 0, 0, mk(3, 1, 0, 0, 0, 2,  1,  0, 0)};
    vt[11] = '{6'h04, 6'h00, 1'b0, 0, 0, mk(3, 1, 0, 0, 0, 1,  1,  0, 0)};
    vt[12] = '{6'h02, 6'h00, 1'b1, 0, 0, mk(3, 1, 0, 0, 0, 2, -1,  0, 0)};
    vt[13] = '{6'h3F, 6'h00, 1'b0, 0, 0, mk(2, 0, 0, 0, 0, 1, -1, -1, 1)};
    vt[14] = '{6'h00, 6'h21, 1'b0, 0, 0, mk(4, 1, 1, 0, 0, 1,  0,  8, 1)};
    vt[15] = '{6'h00, 6'h00, 1'b0, 1, 0, mk(3, 0, 0, 0, 0, 1, -1, -1, 1)};

    bus.op = 6'h00; bus.func = 6'h21; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    bus2.op = 6'h2B; bus2.func = 6'h00; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;

    // Reset held: FETCH with mem_ready=1 would otherwise strobe.
    #12;
    chk("rst.state",   int'(bus.state),   0);
    chk("rst.pc_wr",   int'(bus.pc_wr),   0);
    chk("rst.ir_wr",   int'(bus.ir_wr),   0);
    chk("rst.memrd",   int'(bus.memrd),   0);
    chk("rst.retire",  int'(bus.retire),  0);
    chk("rst.illegal", int'(bus.illegal), 0);
    @(posedge clk); #1;
    chk("rst.state_edge", int'(bus.state), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_instr(vt[i].op, vt[i].func, vt[i].zero, mkrdy(vt[i].fst, vt[i].mst), m);
      compare($sformatf("vec%0d", i), m, vt[i].e);
    end

    // Async reset clears the sticky flag without a clock edge.
    bus.op = 6'h00; bus.func = 6'h21; bus.mem_ready = 1'b1;
    rst = 1'b1; #1;
    chk("arst.illegal", int'(bus.illegal), 0);
    chk("arst.state",   int'(bus.state),   0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel.first_edge_fetch", int'(bus.state), 1);

    // sw parked in MEM, then async reset.
    rst = 1'b1; #1; @(posedge clk); #1;
    rst = 1'b0; bus.op = 6'h2B; bus.func = 6'h00;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.state == 3'd3) break;
    end
    bus.mem_ready = 1'b0; #1;
    chk("swmem.state", int'(bus.state), 3);
    chk("swmem.memwr", int'(bus.memwr), 1);
    #1; rst = 1'b1; #1;
    chk("swrst.memwr",  int'(bus.memwr),  0);
    chk("swrst.state",  int'(bus.state),  0);
    chk("swrst.retire", int'(bus.retire), 0);
    chk("swrst.regwr",  int'(bus.regwr),  0);
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ready = 1'b1;

    ill_sticky = 0;
    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 11);
      rz  = 1'(($urandom_range(0, 1)));
      rdy = '1;
      for (int i = 0; i < 24; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      if (idx == 11) begin
        rop = 6'h3F; rfunc = 6'h00;
        for (int tries = 0; tries < 100; tries++) begin
          rop   = 6'($urandom_range(0, 63));
          rfunc = 6'($urandom_range(0, 63));
          if (tries % 2 == 0) rop = 6'h00;
          if (!is_legal(rop, rfunc)) break;
        end
        e = model(K_X, 0, 0, rz, rdy, ill_sticky);
        ill_sticky = 1;
      end else begin
        rop   = isa[idx].op;
        rfunc = (isa[idx].kind == K_R) ? isa[idx].func : 6'($urandom_range(0, 63));
        e = model(isa[idx].kind, isa[idx].aluop, isa[idx].sel, rz, rdy, ill_sticky);
      end
      run_instr(rop, rfunc, rz, rdy, m);
      compare($sformatf("rnd%0d_op%02h_f%02h", n, rop, rfunc), m, e);
    end

    // mem_ready tied low but ignored: sw completes in 4 cycles.
    @(posedge clk); #1;
    rst2 = 1'b0;
    lat2 = 0; memwr2 = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      memwr2 += int'(bus2.memwr);
      if (bus2.retire) begin
        lat2 = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("nowait.sw_lat",   lat2,   4);
    chk("nowait.sw_memwr", memwr2, 1);
    @(posedge clk); #1;
    chk("nowait.back_fetch", int'(bus2.state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
